// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests on a
// valid/ready port, buffers in-order responses in a small FIFO and hands
// one entry per cycle to decode. Redirects flush the buffer and discard
// stale responses. Misaligned redirects and access faults become tagged
// exception entries, and fetch halts until the next redirect.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [11:0] id_funct12,
  output logic        id_excep,
  output logic [3:0]  id_excep_code
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW+1:0] CREDITS = (PW+2)'(DEPTH);

  // fetch control state
  logic [31:0] fetch_pc;
  logic        halt;      // no new requests until the next redirect
  logic        mis_pend;  // misaligned redirect: push its exception entry next cycle
  logic        req_hold;  // request presented last cycle and not yet accepted
  logic [PW:0] outstanding;
  logic [PW:0] drop_cnt;

  // in-flight PC queue, one slot per live (non-dropped) request
  logic [31:0]   ipc [DEPTH];
  logic [PW-1:0] ipc_wr, ipc_rd;

  // decode-facing FIFO
  logic [31:0]   f_data [DEPTH];
  logic [31:0]   f_pc   [DEPTH];
  logic          f_exc  [DEPTH];
  logic          f_code [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic [PW+1:0] in_use;
  logic          credit_ok, accept, rsp_drop, rsp_push, push, pop, misaligned;
  logic [PW:0]   rsp_dec;

  // Dropped responses still hold a slot, so in-flight stale requests count
  // against the credit exactly like live ones.
  assign in_use     = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok  = in_use < CREDITS;
  // A presented request stays up until taken, even if a fault halts fetch.
  assign imem_req_valid = !rst && !redirect && (req_hold || (credit_ok && !halt));
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req_valid && imem_req_ready;
  assign rsp_drop   = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_push   = imem_rsp_valid && (drop_cnt == '0);
  assign rsp_dec    = (PW+1)'(imem_rsp_valid);
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  // mis_pend only follows a redirect, when every in-flight response is stale,
  // so it never collides with a live response push.
  assign push       = mis_pend || rsp_push;
  assign pop        = id_valid && id_ready;

  // fetch PC, credit accounting, drop counter and halt tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      halt        <= 1'b0;
      mis_pend    <= 1'b0;
      req_hold    <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      halt        <= misaligned;
      mis_pend    <= misaligned;
      req_hold    <= 1'b0;
      outstanding <= outstanding - rsp_dec;
      drop_cnt    <= outstanding - rsp_dec;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      req_hold    <= imem_req_valid && !imem_req_ready;
      outstanding <= outstanding + (PW+1)'(accept) - rsp_dec;
      if (rsp_drop) drop_cnt <= drop_cnt - (PW+1)'(1);
      if (rsp_push && imem_rsp_err) halt <= 1'b1;
      mis_pend    <= 1'b0;
    end
  end

  // in-flight PC queue pointers; stale responses never pop it, so a flush
  // simply restarts both pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipc_wr <= '0;
      ipc_rd <= '0;
    end else if (redirect) begin
      ipc_wr <= '0;
      ipc_rd <= '0;
    end else begin
      if (accept)   ipc_wr <= ipc_wr + 1'b1;
      if (rsp_push) ipc_rd <= ipc_rd + 1'b1;
    end
  end

  // in-flight PC storage
  always_ff @(posedge clk) begin
    if (accept) ipc[ipc_wr] <= fetch_pc;
  end

  // FIFO pointers and occupancy; redirect clears and overrides pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // FIFO storage; exception entries carry a zero instruction word
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      if (mis_pend) begin
        f_data[wr_ptr] <= 32'h0;
        f_pc[wr_ptr]   <= fetch_pc;
        f_exc[wr_ptr]  <= 1'b1;
        f_code[wr_ptr] <= 1'b0;
      end else begin
        f_data[wr_ptr] <= imem_rsp_err ? 32'h0 : imem_rsp_data;
        f_pc[wr_ptr]   <= ipc[ipc_rd];
        f_exc[wr_ptr]  <= imem_rsp_err;
        f_code[wr_ptr] <= imem_rsp_err;
      end
    end
  end

  // decode outputs, all zero while the FIFO is empty
  assign id_valid      = (count != '0);
  assign id_instr      = id_valid ? f_data[rd_ptr] : 32'h0;
  assign id_pc         = id_valid ? f_pc[rd_ptr] : 32'h0;
  assign id_excep      = id_valid && f_exc[rd_ptr];
  assign id_excep_code = {3'b000, id_valid && f_code[rd_ptr]};
  assign id_opcode     = id_instr[6:0];
  assign id_funct3     = id_instr[14:12];
  assign id_funct7     = id_instr[31:25];
  assign id_funct12    = id_instr[31:20];

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a memory model answers requests in order,
// every accepted request pushes its expected decode entry, and a separate
// monitor pops and compares whenever decode takes an entry.
module tb_ifetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic [11:0] id_funct12;
  logic        id_excep;
  logic [3:0]  id_excep_code;

  ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7), .id_funct12(id_funct12),
    .id_excep(id_excep), .id_excep_code(id_excep_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic excep; logic [3:0] code; bit mis; } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, epoch = 0, nonmis = 0, lat = 1, last_due = 0;
  int          rdy_pct = 100, idr_pct = 100;
  int          first_acc = -1, first_id = -1, first_acc_redir = -1;
  bit          halted = 0, prev_hold = 0, rand_err = 0;
  logic [31:0] model_pc = RESET_PC, prev_addr = 32'h0, err_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a ^ 32'hA5A5_0000) * 32'h0001_0003 + 32'h13;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_addr) || (rand_err && ((a[11:2] % 10'd11) == 10'd7));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cyc++;
      rst = 1'b1; redirect = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
      memq.delete(); expq.delete();
      epoch++; nonmis = 0; halted = 0; prev_hold = 0; model_pc = RESET_PC; last_due = 0;
      first_acc = -1; first_id = -1; first_acc_redir = -1;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_id_excep", {27'h0, id_excep, id_excep_code}, 32'h0);
    end
  endtask

  // one clock cycle of stimulus plus request-side modelling
  task automatic step(input bit rd, input logic [31:0] rpc);
    mreq_t m; exp_t e; bit rv; int rep; int due; logic [31:0] ra; bit herr;
    @(negedge clk); cyc++;
    rst = 1'b0; rv = 0; rep = -1; ra = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front(); rv = 1; rep = m.epoch; ra = m.addr;
    end
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? mem_data(ra) : 32'h0;
    imem_rsp_err   = rv ? mem_err(ra) : 1'b0;
    imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    id_ready       = (int'($urandom_range(99)) < idr_pct);
    redirect       = rd;
    redirect_pc    = rpc;
    #1;
    if (prev_hold && !rd) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'h1);
      chk("req_hold_addr", imem_addr, prev_addr);
    end
    if (rd) chk("redirect_no_req", 32'(imem_req_valid), 32'h0);
    else if (halted && !prev_hold) chk("halted_no_req", 32'(imem_req_valid), 32'h0);
    herr = rv && (rep == epoch) && imem_rsp_err;
    if (imem_req_valid && imem_req_ready) begin
      if (first_acc < 0) first_acc = cyc;
      if (first_acc_redir < 0) first_acc_redir = cyc;
      chk("req_addr", imem_addr, model_pc);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{model_pc, due, epoch});
      e.pc = model_pc; e.excep = mem_err(model_pc);
      e.instr = e.excep ? 32'h0 : mem_data(model_pc);
      e.code = e.excep ? 4'd1 : 4'd0; e.mis = 0;
      expq.push_back(e); nonmis++;
      model_pc = model_pc + 32'd4;
    end
    if (rd) begin
      epoch++; expq.delete(); nonmis = 0; model_pc = rpc;
      halted = (rpc[1:0] != 2'b00); first_acc_redir = -1;
      if (halted) begin
        e.pc = rpc; e.instr = 32'h0; e.excep = 1'b1; e.code = 4'd0; e.mis = 1;
        expq.push_back(e);
      end
    end else if (herr) halted = 1;
    prev_hold = imem_req_valid && !imem_req_ready && !rd;
    prev_addr = imem_addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  // monitor: compare every entry decode takes against the scoreboard
  exp_t mon_e;
  int   mon_stale;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (id_valid && first_id < 0) first_id = cyc;
        if (!id_valid) begin
          chk("idle_pc", id_pc, 32'h0);
          chk("idle_instr", id_instr, 32'h0);
        end
        if (id_valid && id_ready && !redirect) begin
          if (expq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_entry @cycle %0d: got pc %h want no entry", cyc, id_pc);
          end else begin
            mon_e = expq.pop_front();
            chk("id_pc", id_pc, mon_e.pc);
            chk("id_instr", id_instr, mon_e.instr);
            chk("id_opcode", 32'(id_opcode), 32'(mon_e.instr[6:0]));
            chk("id_funct3", 32'(id_funct3), 32'(mon_e.instr[14:12]));
            chk("id_funct7", 32'(id_funct7), 32'(mon_e.instr[31:25]));
            chk("id_funct12", 32'(id_funct12), 32'(mon_e.instr[31:20]));
            chk("id_excep", 32'(id_excep), 32'(mon_e.excep));
            chk("id_excep_code", 32'(id_excep_code), 32'(mon_e.code));
            if (!mon_e.mis) nonmis--;
          end
        end
        mon_stale = 0;
        foreach (memq[i]) if (memq[i].epoch != epoch) mon_stale++;
        chk("credit_limit", 32'(mon_stale + nonmis <= DEPTH), 32'h1);
      end
    end
  end

  int rcyc, r;
  logic [31:0] rpc;
  initial begin
    // reset and straight-line fetch with 1-cycle memory
    lat = 1; rdy_pct = 100; idr_pct = 100;
    reset_cycles(3);
    rcyc = cyc + 1;
    run(12);
    chk("first_req_cycle", 32'(first_acc), 32'(rcyc));
    chk("first_id_latency", 32'(first_id - first_acc), 32'(lat + 1));

    // decode stall, then release
    idr_pct = 0;   run(10);
    idr_pct = 100; run(10);

    // redirect with responses in flight on a 3-cycle memory
    lat = 3; run(8);
    step(1'b1, 32'h0000_0100);
    run(15);

    // misaligned redirect: one exception entry then silence
    step(1'b1, 32'h0000_0102);
    run(10);
    chk("mis_drained", 32'(expq.size()), 32'h0);
    chk("mis_silence", 32'(id_valid), 32'h0);
    step(1'b1, 32'h0000_0200);
    rcyc = cyc;
    run(10);
    chk("redirect_to_req", 32'(first_acc_redir - rcyc), 32'h1);

    // access fault on 0x8 halts fetch
    err_addr = 32'h0000_0008; lat = 1;
    reset_cycles(2);
    run(15);
    chk("err_drained", 32'(expq.size()), 32'h0);
    err_addr = 32'hFFFF_FFFF;
    step(1'b1, 32'h0000_0300);
    run(8);

    // PC wrap, then redirect coinciding with a response and a pop
    lat = 3;
    step(1'b1, 32'hFFFF_FFF0);
    run(12);
    for (int i = 0; i < 20; i++) begin
      if (memq.size() > 0 && memq[0].due == cyc + 1 && memq[0].epoch == epoch && id_valid) begin
        step(1'b1, 32'h0000_0400);
        break;
      end
      step(1'b0, 32'h0);
    end
    run(12);

    // randomized traffic
    rand_err = 1;
    for (int blk = 0; blk < 6; blk++) begin
      lat = 1 + int'($urandom_range(3));
      rdy_pct = 40 + int'($urandom_range(60));
      idr_pct = 40 + int'($urandom_range(60));
      if (blk == 3) reset_cycles(2);
      for (int i = 0; i < 500; i++) begin
        r = int'($urandom_range(99));
        if (r < 3) begin
          case ($urandom_range(9))
            0:       rpc = 32'hFFFF_FFF8;
            1:       rpc = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
            default: rpc = {20'h0, 10'($urandom), 2'b00};
          endcase
          step(1'b1, rpc);
        end else begin
          step(1'b0, 32'h0);
        end
      end
    end

    // drain everything through a misaligned redirect
    rand_err = 0; rdy_pct = 100; idr_pct = 100;
    step(1'b1, 32'h0000_0006);
    run(30);
    chk("drain_empty", 32'(expq.size()), 32'h0);
    chk("drain_idle", 32'(id_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
